digit_accumulator: RTL and testbench



---
 rtl/digit_accumulator.sv | 144 ++++++++++++++
 tb/tb_digit_accumulator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_accumulator.sv
// MSB-first digit to binary accumulator: value = value*BASE + digit, shift-add multiply.
// Optional DIGIT_ACC_SATURATE_EN clamps the result to all-ones after overflow.
module digit_accumulator #(
  parameter int BASE       = 10,
  parameter int W_DIGIT    = 4,
  parameter int W_VAL      = 10,
  parameter int MAX_DIGITS = 4,
  parameter int W_CNT      = $clog2(MAX_DIGITS+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_DIGIT-1:0] digit,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic               commit,
  output logic               err_digit,
  output logic [W_VAL-1:0]   out_value,
  output logic [W_CNT-1:0]   out_count,
  output logic               out_overflow,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int W_PROD = W_VAL + W_DIGIT + 1;
  localparam int W_BIT  = $clog2(W_DIGIT + 1);

  localparam logic [W_DIGIT:0]   BASE_C = (W_DIGIT+1)'(BASE);
  localparam logic [W_CNT-1:0]   MAX_C  = W_CNT'(MAX_DIGITS);
  localparam logic [W_BIT-1:0]   LAST_C = W_BIT'(W_DIGIT - 1);
  localparam logic [W_CNT-1:0]   ONE_C  = W_CNT'(1);
  localparam logic [W_BIT-1:0]   BONE_C = W_BIT'(1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [W_VAL-1:0]    acc_q, acc_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [W_DIGIT-1:0]  dig_q, dig_d;
  logic [W_PROD-1:0]   prod_q, prod_d;
  logic [W_BIT-1:0]    bit_q, bit_d;
  logic                err_q, err_d;

  logic [W_PROD-1:0]   acc_ext;
  logic [W_PROD-1:0]   part;
  logic [W_PROD-1:0]   top_part;
  logic [W_PROD-1:0]   sum;

  assign acc_ext = {{(W_DIGIT+1){1'b0}}, acc_q};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    dig_d       = dig_q;
    prod_d      = prod_q;
    bit_d       = bit_q;
    err_d       = 1'b0;
    part        = '0;
    top_part    = '0;
    sum         = '0;
    digit_ready = (state_q == IDLE) && (cnt_q < MAX_C);
    unique case (state_q)
      IDLE: begin
        if (digit_valid && digit_ready) begin
          if ({1'b0, digit} < BASE_C) begin
            dig_d   = digit;
            prod_d  = '0;
            bit_d   = '0;
            state_d = MUL;
          end else begin
            err_d = 1'b1;
          end
        end else if (commit) begin
          state_d = DONE;
        end
      end
      MUL: begin
        if (BASE_C[bit_q]) part = acc_ext << bit_q;
        // BASE == 2^W_DIGIT has a bit beyond the loop; fold it into cycle 0
        if ((bit_q == '0) && BASE_C[W_DIGIT]) top_part = acc_ext << W_DIGIT;
        prod_d = prod_q + part + top_part;
        if (bit_q == LAST_C) state_d = ADD;
        else bit_d = bit_q + BONE_C;
      end
      ADD: begin
        sum   = prod_q + {{(W_PROD-W_DIGIT){1'b0}}, dig_q};
        ovf_d = ovf_q | (|sum[W_PROD-1:W_VAL]);
        acc_d = sum[W_VAL-1:0];
`ifdef DIGIT_ACC_SATURATE_EN
        if (ovf_d) acc_d = '1;
`else
        acc_d = sum[W_VAL-1:0];
`endif
        cnt_d   = cnt_q + ONE_C;
        state_d = IDLE;
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
      prod_q  <= '0;
      bit_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      prod_q  <= prod_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
    end
  end

  assign err_digit    = err_q;
  assign out_value    = acc_q;
  assign out_count    = cnt_q;
  assign out_overflow = ovf_q;
  assign out_valid    = (state_q == DONE);

endmodule

// File: tb/tb_digit_accumulator.sv
// Scoreboard bench for digit_accumulator: directed scenarios then random entries.
// Expected results come from plain integer arithmetic over the accepted digits.
module tb_digit_accumulator;

  localparam int BASE       = 10;
  localparam int W_DIGIT    = 4;
  localparam int W_VAL      = 10;
  localparam int MAX_DIGITS = 4;
  localparam int W_CNT      = $clog2(MAX_DIGITS+1);
  localparam longint MAXV   = (longint'(1) << W_VAL) - 1;
`ifdef DIGIT_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    longint v;
    longint c;
    longint o;
  } exp_t;

  logic               clk;
  logic               rst;
  logic [W_DIGIT-1:0] digit;
  logic               digit_valid;
  logic               digit_ready;
  logic               commit;
  logic               err_digit;
  logic [W_VAL-1:0]   out_value;
  logic [W_CNT-1:0]   out_count;
  logic               out_overflow;
  logic               out_valid;
  logic               out_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   mdig[$];
  exp_t me;

  digit_accumulator #(
    .BASE(BASE), .W_DIGIT(W_DIGIT), .W_VAL(W_VAL), .MAX_DIGITS(MAX_DIGITS)
  ) dut (
    .clk(clk), .rst(rst),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .commit(commit), .err_digit(err_digit),
    .out_value(out_value), .out_count(out_count),
    .out_overflow(out_overflow), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(int q[$]);
    exp_t   e;
    longint t = 0;
    bit     o = 1'b0;
    foreach (q[i]) begin
      t = t * BASE + q[i];
      if (t > MAXV) o = 1'b1;
    end
    e.c = q.size();
    e.o = o;
    e.v = o ? (SAT ? MAXV : t % (MAXV + 1)) : t;
    return e;
  endfunction

  // Monitor: a result leaves the block on every valid&ready cycle
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out value %0d required none", out_value);
        end else begin
          me = sb.pop_front();
          chk("out_value", out_value, me.v);
          chk("out_count", out_count, me.c);
          chk("out_overflow", out_overflow, me.o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(int d);
    int n  = 0;
    int lo = 0;
    digit       = W_DIGIT'(d);
    digit_valid = 1'b1;
    while (!digit_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL digit_wait timeout actual %0d required <100", n);
      digit_valid = 1'b0;
      return;
    end
    tick();
    digit_valid = 1'b0;
    if (d >= BASE) begin
      chk("err_pulse", err_digit, 1);
      chk("cnt_unchanged", out_count, mdig.size());
      tick();
      chk("err_clear", err_digit, 0);
    end else begin
      mdig.push_back(d);
      chk("no_err", err_digit, 0);
      if (mdig.size() < MAX_DIGITS) begin
        while (!digit_ready && lo < 50) begin
          lo++;
          tick();
        end
        chk("ready_low_cycles", lo, W_DIGIT + 1);
      end else begin
        repeat (W_DIGIT + 1) tick();
      end
    end
  endtask

  task automatic do_commit(int hold);
    sb.push_back(model(mdig));
    mdig.delete();
    commit = 1'b1;
    tick();
    commit      = 1'b0;
    digit_valid = 1'b0;
    chk("valid_after_commit", out_valid, 1);
    if (hold > 0) begin
      repeat (hold) tick();
      chk("valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_after_pop", digit_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int d;
    int bad;
    rst         = 1'b1;
    digit       = '0;
    digit_valid = 1'b0;
    commit      = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_digit_ready", digit_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_digit, 0);
    chk("rst_count", out_count, 0);
    chk("rst_value", out_value, 0);
    chk("rst_ovf", out_overflow, 0);

    // 409
    send_digit(4);
    send_digit(0);
    send_digit(9);
    do_commit(0);

    // 9999 overflows
    repeat (4) send_digit(9);
    do_commit(1);

    // invalid digit dropped
    send_digit(12);
    send_digit(7);
    do_commit(0);

    // full entry refuses further digits
    send_digit(1);
    send_digit(2);
    send_digit(3);
    send_digit(4);
    digit       = W_DIGIT'(3);
    digit_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      if (digit_ready || err_digit) bad++;
      tick();
    end
    chk("full_no_accept", bad, 0);
    do_commit(0);

    // empty commit held
    do_commit(5);

    // reset in the middle of a multiply
    send_digit(3);
    digit       = W_DIGIT'(5);
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdig.delete();
    chk("midrst_ready", digit_ready, 1);
    chk("midrst_count", out_count, 0);
    chk("midrst_value", out_value, 0);
    chk("midrst_valid", out_valid, 0);
    send_digit(6);
    do_commit(0);

    for (int e = 0; e < 40; e++) begin
      nd = $urandom_range(0, 6);
      for (int k = 0; k < nd; k++) begin
        if (mdig.size() < MAX_DIGITS) begin
          if ($urandom_range(0, 7) == 0) d = $urandom_range(BASE, 15);
          else d = $urandom_range(0, BASE - 1);
          send_digit(d);
        end
      end
      do_commit($urandom_range(0, 3));
    end

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
